// File: rtl/frame_sched_if.sv
// Channel-request and serializer-side signal bundle for frame_sched.
// The scheduler takes the slave view; the channels/serializer side takes the master view.
interface frame_sched_if #(
    parameter int unsigned NCH = 4
);
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [16*NCH-1:0] req_uid;
    logic [8*NCH-1:0]  req_zid;
    logic [8*NCH-1:0]  req_cnt;
    logic [8*NCH-1:0]  req_ftype;
    logic [8*NCH-1:0]  req_rssi;

    logic [15:0]       uid;
    logic [7:0]        zid;
    logic [7:0]        cnt;
    logic [7:0]        ftype;
    logic [7:0]        rssi;
    logic              den;
    logic              ser_drdy;
    logic [2:0]        grant_id;
    logic              busy;
    logic              timeout;

    modport master (
        output req_valid, req_uid, req_zid, req_cnt, req_ftype, req_rssi, ser_drdy,
        input  req_ready, uid, zid, cnt, ftype, rssi, den, grant_id, busy, timeout
    );

    modport slave (
        input  req_valid, req_uid, req_zid, req_cnt, req_ftype, req_rssi, ser_drdy,
        output req_ready, uid, zid, cnt, ftype, rssi, den, grant_id, busy, timeout
    );
endinterface

// File: rtl/frame_sched.sv
// Round-robin scheduler sharing one 8-byte frame serializer between NCH channels,
// with one-deep per-channel holding slots, byte tracking, timeout and inter-frame gap.
module frame_sched #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned NBYTES  = 8,
    parameter int unsigned GAP     = 16,
    parameter int unsigned TIMEOUT = 8191
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_sched_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StGap} state_e;

    state_e         r_state;
    state_e         w_state_d;

    logic [NCH-1:0] r_pending;
    logic [2:0]     r_ptr;
    logic [2:0]     r_grant;
    logic [15:0]    r_slot_uid   [NCH];
    logic [7:0]     r_slot_zid   [NCH];
    logic [7:0]     r_slot_cnt   [NCH];
    logic [7:0]     r_slot_ftype [NCH];
    logic [7:0]     r_slot_rssi  [NCH];
    logic [15:0]    r_uid;
    logic [7:0]     r_zid;
    logic [7:0]     r_cnt;
    logic [7:0]     r_ftype;
    logic [7:0]     r_rssi;
    logic           r_drdy_q;
    logic [3:0]     r_byte;
    logic [15:0]    r_to;
    logic [7:0]     r_gap;

    logic           w_found;
    logic [2:0]     w_win;
    logic [2:0]     w_ptr_nxt;
    logic           w_rise;
    logic           w_den;
    logic           w_timeout;
    logic [15:0]    w_sel_uid;
    logic [7:0]     w_sel_zid;
    logic [7:0]     w_sel_cnt;
    logic [7:0]     w_sel_ftype;
    logic [7:0]     w_sel_rssi;

    // Two passes give the wrap: first slots at/above ptr, then those below it.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && r_pending[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = 3'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && r_pending[i] && (i < int'(r_ptr))) begin
                w_found = 1'b1;
                w_win   = 3'(i);
            end
        end
    end

    always_comb begin
        w_sel_uid   = 16'd0;
        w_sel_zid   = 8'd0;
        w_sel_cnt   = 8'd0;
        w_sel_ftype = 8'd0;
        w_sel_rssi  = 8'd0;
        for (int i = 0; i < NCH; i++) begin
            if (3'(i) == w_win) begin
                w_sel_uid   = r_slot_uid[i];
                w_sel_zid   = r_slot_zid[i];
                w_sel_cnt   = r_slot_cnt[i];
                w_sel_ftype = r_slot_ftype[i];
                w_sel_rssi  = r_slot_rssi[i];
            end
        end
    end

    assign w_ptr_nxt = (r_grant == 3'(NCH - 1)) ? 3'd0 : r_grant + 3'd1;
    assign w_rise    = bus.ser_drdy & ~r_drdy_q;

    always_comb begin
        w_state_d = r_state;
        w_den     = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found) w_state_d = StLoad;
            end
            StLoad: begin
                w_den     = 1'b1;
                w_state_d = StWait;
            end
            StWait: begin
                if (w_rise) begin
                    if (r_byte == 4'(NBYTES - 1)) w_state_d = StGap;
                end else if (r_to == 16'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_state_d = StGap;
                end
            end
            StGap: begin
                if (r_gap == 8'(GAP - 1)) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ptr     <= 3'd0;
            r_grant   <= 3'd0;
            r_uid     <= 16'd0;
            r_zid     <= 8'd0;
            r_cnt     <= 8'd0;
            r_ftype   <= 8'd0;
            r_rssi    <= 8'd0;
            r_drdy_q  <= 1'b0;
            r_byte    <= 4'd0;
            r_to      <= 16'd0;
            r_gap     <= 8'd0;
            for (int i = 0; i < NCH; i++) begin
                r_slot_uid[i]   <= 16'd0;
                r_slot_zid[i]   <= 8'd0;
                r_slot_cnt[i]   <= 8'd0;
                r_slot_ftype[i] <= 8'd0;
                r_slot_rssi[i]  <= 8'd0;
            end
        end else begin
            r_drdy_q <= bus.ser_drdy;
            for (int i = 0; i < NCH; i++) begin
                if (r_state == StLoad && 3'(i) == r_grant) begin
                    r_pending[i] <= 1'b0;
                end else if (bus.req_valid[i] && !r_pending[i]) begin
                    r_pending[i]    <= 1'b1;
                    r_slot_uid[i]   <= bus.req_uid[16*i +: 16];
                    r_slot_zid[i]   <= bus.req_zid[8*i +: 8];
                    r_slot_cnt[i]   <= bus.req_cnt[8*i +: 8];
                    r_slot_ftype[i] <= bus.req_ftype[8*i +: 8];
                    r_slot_rssi[i]  <= bus.req_rssi[8*i +: 8];
                end
            end
            // Fields are loaded on the IDLE->LOAD edge so they are valid alongside den.
            if (r_state == StIdle && w_found) begin
                r_uid   <= w_sel_uid;
                r_zid   <= w_sel_zid;
                r_cnt   <= w_sel_cnt;
                r_ftype <= w_sel_ftype;
                r_rssi  <= w_sel_rssi;
                r_grant <= w_win;
            end
            if (r_state == StLoad) begin
                r_ptr  <= w_ptr_nxt;
                r_byte <= 4'd0;
                r_to   <= 16'd0;
            end
            if (r_state == StWait) begin
                if (w_rise) begin
                    r_byte <= r_byte + 4'd1;
                    r_to   <= 16'd0;
                end else begin
                    r_to   <= r_to + 16'd1;
                end
            end
            r_gap <= (r_state == StGap) ? r_gap + 8'd1 : 8'd0;
        end
    end

    assign bus.req_ready = ~r_pending;
    assign bus.uid       = r_uid;
    assign bus.zid       = r_zid;
    assign bus.cnt       = r_cnt;
    assign bus.ftype     = r_ftype;
    assign bus.rssi      = r_rssi;
    assign bus.den       = w_den;
    assign bus.grant_id  = r_grant;
    assign bus.busy      = (r_state != StIdle);
    assign bus.timeout   = w_timeout;

endmodule

// File: doc/frame_sched.md
# frame_sched

Scheduler that shares the single 8-byte frame serializer (`frame_out`-style: `den` load, eight paced `drdy` byte strobes) between NCH receiver channels. Each channel offers one decoded frame record (uid, zid, cnt, type, rssi) through a valid/ready handshake into a one-deep holding slot. The block picks a winner round-robin, pulses `den` with the winner's fields, and tracks serializer completion by counting `drdy` rising edges. It then enforces an inter-frame gap before issuing the next frame. It sits between the per-channel demodulators and the serializer.

## Interface
- NCH, 4: number of requesting channels (2..8)
- NBYTES, 8: `drdy` rising edges per serialized frame
- GAP, 16: idle cycles after last byte before next `den` (≥1)
- TIMEOUT, 8191: max cycles between `den`/byte and next `drdy` rise (must exceed serializer byte period 3301)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NCH  channel i has a record
- req_ready  out  NCH  channel i slot empty; transfer when valid&ready
- req_uid  in  16*NCH  channel i at [16i+15:16i]
- req_zid, req_cnt, req_type, req_rssi  in  8*NCH each  channel i at [8i+7:8i]
- uid  out  16, zid/cnt/type/rssi  out  8 each  fields to serializer, held stable from `den` until next `den`
- den  out  1  one-cycle load strobe to serializer
- ser_drdy  in  1  serializer byte strobe
- grant_id  out  3  channel of frame currently/last issued
- busy  out  1  high in LOAD, WAIT, GAP
- timeout  out  1  one-cycle pulse on serializer timeout

## Operation
- Slots: pending[i] set on valid&ready (fields captured); cleared on the edge that issues `den` for channel i. req_ready[i] = ~pending[i] (combinational from register).
- Arbitration: search pending from ptr upward, wrapping mod NCH; first set wins. After grant, ptr <= winner+1 mod NCH.
- FSM:
  - IDLE: if any pending → LOAD.
  - LOAD: register winner fields to outputs, den=1, clear pending[winner], grant_id=winner, update ptr, clear byte and timeout counters → WAIT.
  - WAIT: ser_drdy rise (drdy & ~drdy_q) increments byte counter and clears the timeout counter. On the NBYTES-th rise → GAP. If the timeout counter reaches TIMEOUT → pulse timeout, → GAP.
  - GAP: count GAP cycles → IDLE.
- Counters: byte counter 4 bits; timeout counter 16 bits, saturates by FSM exit; gap counter 8 bits.
- A rise on ser_drdy outside WAIT is ignored. drdy_q is updated every cycle.
- Reset: state IDLE; pending=0; ptr=0; den=0; uid/zid/cnt/type/rssi=0; grant_id=0; busy=0; timeout=0; req_ready=all 1s; drdy_q=0. Reset mid-frame discards all slots with no `den` issued.

## Timing
- Accept at edge t → pending visible t+1 → IDLE sees it, LOAD at t+2 with den=1 and fields valid in the same cycle.
- den is high exactly one cycle. req_ready[winner] returns high the cycle after den.
- A channel may reload its slot while its previous frame is serializing. At most one record per channel is queued.
- Last drdy rise at cycle r → GAP for cycles r+1..r+GAP → IDLE at r+GAP+1 → earliest next den at r+GAP+2.
- Simultaneous accept on channel j and grant of channel i≠j: both occur. The new pending[j] competes in the next IDLE.
- Timeout pulse coincides with the WAIT→GAP transition.

## Test plan
- Single channel: ch2 offers uid=0x1234, zid=0x05, cnt=0x01, type=0x02, rssi=0x80 → den 2 cycles later with those fields, grant_id=2, busy high. After 8 modelled drdy rises plus 16 gap cycles → IDLE, busy=0.
- Round-robin: all 4 channels valid at once after reset → den order ch0, ch1, ch2, ch3. Refill ch0 during ch3's frame → ch0 next.
- Fairness wrap: ptr=3, pending {1,3} → ch3 granted, then ch1.
- Back-pressure: ch1 valid held high while its slot is full → req_ready[1]=0 and no capture. Slot accepts again the cycle after den.
- Timeout: serializer model stops after 3 bytes → timeout pulse 8191 cycles after the 3rd rise, then GAP, then next pending frame issued.
- Async reset asserted mid-WAIT with 2 slots pending → all outputs at reset values, req_ready=4'b1111, and no den after release until a new request arrives.
